ahb_gpio_irq: RTL and testbench
===============================

# ahb_gpio_irq

AHB-Lite slave GPIO port with a parametrised pin count, per-pin direction control, a synchronised input path, and edge-triggered interrupts with per-pin enable and write-1-to-clear status. It is the next-generation GPIO peripheral on the AHB fabric and replaces the fixed 16-bit, whole-port-direction GPIO. It keeps the odd/even parity generation and checking on the pin bus.

## Interface
Parameters:
- GPIO_WIDTH, 16, number of pins; legal range 1..31.
- SYNC_STAGES, 2, flops in the input synchroniser; legal range 2..4.
- BASE_MASK, 8'hFF, HADDR bits compared for register decode.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite address-phase controls.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data, data phase.
- HREADYOUT  out  1  tied 1 (zero wait states).
- HRESP  out  1  tied 0 (OKAY).
- GPIOIN  in  GPIO_WIDTH+1  pin inputs; the top bit is the parity bit.
- GPIOOUT  out  GPIO_WIDTH+1  pin outputs; the top bit is the generated parity.
- GPIOEN  out  GPIO_WIDTH  per-pin output enable; equals DIR.
- PARITYSEL  in  1  1 = odd parity, 0 = even parity.
- PARITYERR  out  1  parity mismatch on the synchronised input word.
- IRQ  out  1  interrupt, level, registered.

## Operation
- Register map (byte offsets, word aligned, decoded on HADDR[7:0]):
  - 0x00 DATA: RW, output value.
  - 0x04 DIR: RW, 1 = pin is an output.
  - 0x08 IN: RO, synchronised pin value. An output pin reads back its DATA bit. The top bit is the parity bit.
  - 0x0C IE: RW, per-pin interrupt enable.
  - 0x10 EDGE: RW, 1 = rising edge, 0 = falling edge.
  - 0x14 IS: W1C, interrupt status.
- Unmapped offsets read 0; writes to them are ignored. Unused upper bits read 0.
- A transfer is valid when HSEL & HREADY & HTRANS[1] at the address phase. Address, write flag and valid are registered, and the write is applied at the end of the data phase using HWDATA.
- Reads: HRDATA is a combinational mux selected by the registered address, valid during the data phase.
- Input path: GPIOIN passes through SYNC_STAGES flops, then a one-flop delay for edge detection.
- Edge event on pin i: (DIR[i]=0) & IE[i] & the selected edge seen between the last two synchronised samples.
- An event sets IS[i]. Writing 1 to IS[i] clears it. If a set and a clear occur in the same cycle, the set wins.
- IRQ is registered: |(IS & IE).
- Changing IE, DIR or EDGE never modifies IS.
- GPIOOUT[GPIO_WIDTH-1:0] = DATA. Bits with DIR=0 still drive DATA; GPIOEN qualifies them.

## Timing
- Reset value of every register and output is 0: DATA, DIR, IE, EDGE, IS, synchroniser, IRQ, HRDATA, GPIOEN, PARITYERR.
- After reset, GPIOOUT[GPIO_WIDTH] = parity(0) = PARITYSEL, i.e. 1 when odd.
- Write latency: the register updates at the clock edge ending the data phase and is visible on GPIOOUT/GPIOEN in the next cycle.
- Read-after-write back-to-back to the same register returns the new value.
- Input latency: a GPIOIN change appears in IN after SYNC_STAGES edges.
- IS sets at SYNC_STAGES+1 edges after the pin change. IRQ rises one edge after that.
- A W1C write that clears the last pending bit drops IRQ one edge after the write completes.
- HREADY=0 holds the registered address-phase state unchanged.
- Reset assertion mid-transfer aborts the transfer. Registers clear asynchronously, and the first edge sample after release is suppressed (no spurious IS set).

## Configuration
- AHB_GPIO_IRQ_PARITY_EN defined:
  - GPIOOUT[GPIO_WIDTH] = parity(DATA, PARITYSEL).
  - PARITYERR = IN[GPIO_WIDTH] != parity(IN[GPIO_WIDTH-1:0], PARITYSEL), combinational from the synchronised word.
- Not defined:
  - GPIOOUT[GPIO_WIDTH] tied 0.
  - PARITYERR tied 0.
  - IN[GPIO_WIDTH] reads 0.
  - PARITYSEL unused.

## Structure
- Package ahb_gpio_irq_pkg holds:
  - Register offset localparams: DATA_OFS, DIR_OFS, IN_OFS, IE_OFS, EDGE_OFS, IS_OFS.
  - HTRANS encodings.
  - The parity function.
- Sub-module gpio_sync_edge, parametrised on width and stages: synchroniser, delay flop, and per-pin rise/fall pulses.
- Top level contains the bus decode, the register file and the IRQ logic.

## Test plan
- Reset, then read all six offsets → all 0. GPIOOUT top bit = PARITYSEL. IRQ = 0.
- Write DIR=0x00FF, then DATA=0xA5A5 → GPIOEN=0x00FF, GPIOOUT[15:0]=0xA5A5. A read of IN returns 0x??A5, with the low byte from DATA and the high byte from the pins.
- IE=0x0100, EDGE=0x0100, drive GPIOIN[8] 0→1:
  - IS=0x0100 after 3 edges and IRQ=1 after 4.
  - Writing IS=0x0100 drops IRQ. A falling edge then leaves IS at 0.
- Hold a rising edge on pin 9 (IE set) in the same cycle as a W1C of IS bit 9 → IS[9] remains 1.
- PARITYSEL=0, GPIOIN=0x1_0001 → PARITYERR=0 after sync. GPIOIN=0x0_0001 → PARITYERR=1. With the macro undefined → PARITYERR always 0.
- Sequence HREADY=0 during an address phase, a back-to-back write/read to IE, and HRESETn pulsed mid-write → no corrupted registers, read data correct, full clear on reset.

Source files
------------

// File: rtl/ahb_gpio_irq_pkg.sv
// Shared definitions for the AHB GPIO: register offsets, HTRANS encodings,
// registered address-phase record and the pin-bus parity function.
package ahb_gpio_irq_pkg;

    localparam logic [7:0] DATA_OFS = 8'h00;
    localparam logic [7:0] DIR_OFS  = 8'h04;
    localparam logic [7:0] IN_OFS   = 8'h08;
    localparam logic [7:0] IE_OFS   = 8'h0C;
    localparam logic [7:0] EDGE_OFS = 8'h10;
    localparam logic [7:0] IS_OFS   = 8'h14;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic [7:0] addr;
    } meta_t;

    // Parity bit that makes the word plus bit even (odd=0) or odd (odd=1).
    function automatic logic parity(input logic [31:0] dat, input logic odd);
        return (^dat) ^ odd;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser + delay flop producing per-pin rise/fall pulses.
// Latency: sync out after STAGES edges, pulses one cycle wide; no backpressure.
// Edge pulses stay masked until the delay flop holds a post-reset sample.
module gpio_sync_edge #(
    parameter int WIDTH  = 17,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]             dly_q;
    logic [STAGES:0]              prime_q;
    logic                         primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
            dly_q   <= '0;
            prime_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], din};
            dly_q   <= stage_q[STAGES-1];
            prime_q <= {prime_q[STAGES-1:0], 1'b1};
        end
    end

    assign primed = prime_q[STAGES];
    assign sync   = stage_q[STAGES-1];
    assign rise   = sync & ~dly_q & {WIDTH{primed}};
    assign fall   = ~sync & dly_q & {WIDTH{primed}};

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO with per-pin direction, synchronised inputs and W1C edge IRQs.
// Latency: zero wait states, writes land at data-phase end, IRQ registered; HREADY=0 stalls the bus pipe.
// Optional pin-bus parity generation/checking is enabled by AHB_GPIO_IRQ_PARITY_EN.
module ahb_gpio_irq
    import ahb_gpio_irq_pkg::*;
#(
    parameter int         GPIO_WIDTH  = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BASE_MASK   = 8'hFF
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic                  HWRITE,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic [GPIO_WIDTH:0]   GPIOIN,
    output logic [GPIO_WIDTH:0]   GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIOEN,
    input  logic                  PARITYSEL,
    output logic                  PARITYERR,
    output logic                  IRQ
);

    meta_t                 dph_q;
    logic                  addr_vld;
    logic                  wr_en;
    logic [GPIO_WIDTH-1:0] data_q, dir_q, ie_q, edge_q, is_q;
    logic                  irq_q;
    logic [GPIO_WIDTH-1:0] is_set, is_clr;
    logic [GPIO_WIDTH:0]   sync_dat, rise, fall;
    logic [GPIO_WIDTH:0]   in_val;
    logic                  out_par, in_par;
    logic [31:0]           rd_dat;

    assign addr_vld = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

    // Address phase is only accepted (and the data phase only ends) with HREADY high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_q <= '0;
        end else if (HREADY) begin
            dph_q.vld  <= addr_vld;
            dph_q.wr   <= HWRITE;
            dph_q.addr <= HADDR[7:0] & BASE_MASK;
        end
    end

    assign wr_en = dph_q.vld & dph_q.wr & HREADY;

    gpio_sync_edge #(
        .WIDTH  (GPIO_WIDTH + 1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .din   (GPIOIN),
        .sync  (sync_dat),
        .rise  (rise),
        .fall  (fall)
    );

    assign is_set = ie_q & ~dir_q & ((edge_q & rise[GPIO_WIDTH-1:0]) | (~edge_q & fall[GPIO_WIDTH-1:0]));
    assign is_clr = (wr_en && dph_q.addr == IS_OFS) ? HWDATA[GPIO_WIDTH-1:0] : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_q <= '0;
            dir_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            is_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && dph_q.addr == DATA_OFS) data_q <= HWDATA[GPIO_WIDTH-1:0];
            if (wr_en && dph_q.addr == DIR_OFS)  dir_q  <= HWDATA[GPIO_WIDTH-1:0];
            if (wr_en && dph_q.addr == IE_OFS)   ie_q   <= HWDATA[GPIO_WIDTH-1:0];
            if (wr_en && dph_q.addr == EDGE_OFS) edge_q <= HWDATA[GPIO_WIDTH-1:0];
            // Set applied after clear so a simultaneous event wins.
            is_q  <= (is_q & ~is_clr) | is_set;
            irq_q <= |(is_q & ie_q);
        end
    end

`ifdef AHB_GPIO_IRQ_PARITY_EN
    assign out_par   = parity(32'(data_q), PARITYSEL);
    assign in_par    = sync_dat[GPIO_WIDTH];
    assign PARITYERR = sync_dat[GPIO_WIDTH] != parity(32'(sync_dat[GPIO_WIDTH-1:0]), PARITYSEL);
`else
    wire unused_par = ^{PARITYSEL, sync_dat[GPIO_WIDTH]};
    assign out_par   = 1'b0;
    assign in_par    = 1'b0;
    assign PARITYERR = 1'b0;
`endif

    assign in_val = {in_par, (dir_q & data_q) | (~dir_q & sync_dat[GPIO_WIDTH-1:0])};

    always_comb begin
        rd_dat = '0;
        if (dph_q.vld && !dph_q.wr) begin
            case (dph_q.addr)
                DATA_OFS: rd_dat = 32'(data_q);
                DIR_OFS:  rd_dat = 32'(dir_q);
                IN_OFS:   rd_dat = 32'(in_val);
                IE_OFS:   rd_dat = 32'(ie_q);
                EDGE_OFS: rd_dat = 32'(edge_q);
                IS_OFS:   rd_dat = 32'(is_q);
                default:  rd_dat = '0;
            endcase
        end
    end

    wire unused_bits = ^{HADDR[31:8], HWDATA[31:GPIO_WIDTH], rise[GPIO_WIDTH], fall[GPIO_WIDTH]};

    assign HRDATA    = rd_dat;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign GPIOOUT   = {out_par, data_q};
    assign GPIOEN    = dir_q;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed bench for ahb_gpio_irq: register vector table plus hand-written
// sequences for IRQ timing, W1C races, parity, stalls and mid-transfer reset.
module tb_ahb_gpio_irq;
    import ahb_gpio_irq_pkg::*;

    localparam int W = 16;
`ifdef AHB_GPIO_IRQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
    logic [31:0]   HADDR = '0, HWDATA = '0;
    logic [1:0]    HTRANS = HTRANS_IDLE;
    logic [31:0]   HRDATA;
    logic          HREADYOUT, HRESP;
    logic [W:0]    GPIOIN = '0;
    logic [W:0]    GPIOOUT;
    logic [W-1:0]  GPIOEN;
    logic          PARITYSEL = 1'b0;
    logic          PARITYERR, IRQ;

    ahb_gpio_irq dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HWRITE(HWRITE),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT),
        .GPIOEN(GPIOEN), .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] dat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addr_phase(input bit wr, input logic [7:0] addr);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = {24'h0, addr};
    endtask

    task automatic idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [7:0] addr, input logic [31:0] dat);
        addr_phase(1'b1, addr);
        @(negedge HCLK);
        idle();
        HWDATA = dat;
        @(negedge HCLK);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] dat);
        addr_phase(1'b0, addr);
        @(negedge HCLK);
        idle();
        dat = HRDATA;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        vecs.push_back(vec_t'{1'b0, DATA_OFS, 32'h0, "rst_data"});
        vecs.push_back(vec_t'{1'b0, DIR_OFS,  32'h0, "rst_dir"});
        vecs.push_back(vec_t'{1'b0, IN_OFS,   32'h0, "rst_in"});
        vecs.push_back(vec_t'{1'b0, IE_OFS,   32'h0, "rst_ie"});
        vecs.push_back(vec_t'{1'b0, EDGE_OFS, 32'h0, "rst_edge"});
        vecs.push_back(vec_t'{1'b0, IS_OFS,   32'h0, "rst_is"});
        vecs.push_back(vec_t'{1'b1, DIR_OFS,  32'h0000_00FF, "w_dir"});
        vecs.push_back(vec_t'{1'b1, DATA_OFS, 32'h0000_A5A5, "w_data"});
        vecs.push_back(vec_t'{1'b0, DIR_OFS,  32'h0000_00FF, "dir_rb"});
        vecs.push_back(vec_t'{1'b0, DATA_OFS, 32'h0000_A5A5, "data_rb"});
        vecs.push_back(vec_t'{1'b1, 8'h18,    32'hDEAD_BEEF, "w_unmapped"});
        vecs.push_back(vec_t'{1'b0, 8'h18,    32'h0, "unmapped_rd"});
        vecs.push_back(vec_t'{1'b0, 8'h02,    32'h0, "unaligned_rd"});
        vecs.push_back(vec_t'{1'b0, DIR_OFS,  32'h0000_00FF, "dir_after_unmapped"});
        vecs.push_back(vec_t'{1'b1, IE_OFS,   32'hFFFF_0100, "w_ie"});
        vecs.push_back(vec_t'{1'b0, IE_OFS,   32'h0000_0100, "ie_upper_dropped"});
        vecs.push_back(vec_t'{1'b1, EDGE_OFS, 32'h0000_0100, "w_edge"});
        vecs.push_back(vec_t'{1'b0, EDGE_OFS, 32'h0000_0100, "edge_rb"});

        // Reset state
        repeat (2) @(negedge HCLK);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_gpioen", 32'(GPIOEN), 32'h0);
        check("rst_gpioout", 32'(GPIOOUT), 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_parityerr", 32'(PARITYERR), 32'h0);
        PARITYSEL = 1'b1;
        #1 check("rst_outpar_odd", 32'(GPIOOUT[W]), 32'(PAR_EN));
        PARITYSEL = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].dat);
            end else begin
                bus_read(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].dat);
            end
        end

        check("gpioen", 32'(GPIOEN), 32'h00FF);
        check("gpioout_lo", 32'(GPIOOUT[W-1:0]), 32'hA5A5);
        check("outpar_even", 32'(GPIOOUT[W]), 32'h0);
        PARITYSEL = 1'b1;
        #1 check("outpar_odd", 32'(GPIOOUT[W]), 32'(PAR_EN));
        PARITYSEL = 1'b0;
        @(negedge HCLK);

        // Mixed IN read: low byte from DATA, high byte from pins
        GPIOIN = 17'h0_3C5A;
        repeat (3) @(negedge HCLK);
        bus_read(IN_OFS, rd);
        check("in_mixed", rd, 32'h0000_3CA5);
        bus_read(IS_OFS, rd);
        check("is_no_ie", rd, 32'h0);

        // Rising edge on pin 8: IS after 3 edges, IRQ after 4
        GPIOIN[8] = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 check("irq_before_4", 32'(IRQ), 32'h0);
        @(posedge HCLK);
        #1 check("irq_at_4", 32'(IRQ), 32'h1);
        @(negedge HCLK);
        bus_read(IS_OFS, rd);
        check("is_pin8", rd, 32'h0000_0100);
        bus_write(IS_OFS, 32'h0000_0100);
        check("irq_lag_w1c", 32'(IRQ), 32'h1);
        @(negedge HCLK);
        check("irq_drop_w1c", 32'(IRQ), 32'h0);
        GPIOIN[8] = 1'b0;
        repeat (5) @(negedge HCLK);
        bus_read(IS_OFS, rd);
        check("is_fall_ignored", rd, 32'h0);
        check("irq_fall_ignored", 32'(IRQ), 32'h0);

        // Set and W1C of pin 9 on the same edge: set wins
        bus_write(IE_OFS, 32'h0000_0300);
        bus_write(EDGE_OFS, 32'h0000_0300);
        GPIOIN[9] = 1'b1;
        @(negedge HCLK);
        bus_write(IS_OFS, 32'h0000_0200);
        bus_read(IS_OFS, rd);
        check("is_set_wins", rd, 32'h0000_0200);
        bus_write(IS_OFS, 32'h0000_0200);
        bus_read(IS_OFS, rd);
        check("is_w1c", rd, 32'h0);

        // Parity checking on the synchronised word
        bus_write(IE_OFS, 32'h0);
        GPIOIN = 17'h1_0001;
        repeat (3) @(negedge HCLK);
        check("perr_ok", 32'(PARITYERR), 32'h0);
        bus_read(IN_OFS, rd);
        check("in_parbit", rd, {15'h0, PAR_EN, 16'h00A5});
        GPIOIN = 17'h0_0001;
        repeat (3) @(negedge HCLK);
        check("perr_bad", 32'(PARITYERR), 32'(PAR_EN));
        PARITYSEL = 1'b1;
        #1 check("perr_odd_ok", 32'(PARITYERR), 32'h0);
        PARITYSEL = 1'b0;
        @(negedge HCLK);

        // HREADY low during an address phase: transfer ignored
        addr_phase(1'b1, DATA_OFS);
        HREADY = 1'b0;
        @(negedge HCLK);
        idle();
        HREADY = 1'b1;
        HWDATA = 32'h0000_FFFF;
        @(negedge HCLK);
        bus_read(DATA_OFS, rd);
        check("hready_addr_stall", rd, 32'h0000_A5A5);

        // HREADY low during a data phase: write takes the final HWDATA
        addr_phase(1'b1, DATA_OFS);
        @(negedge HCLK);
        idle();
        HREADY = 1'b0;
        HWDATA = 32'h0000_1234;
        @(negedge HCLK);
        HREADY = 1'b1;
        HWDATA = 32'h0000_5678;
        @(negedge HCLK);
        bus_read(DATA_OFS, rd);
        check("hready_data_stall", rd, 32'h0000_5678);
        check("gpioout_stall", 32'(GPIOOUT[W-1:0]), 32'h5678);

        // Back-to-back write then read of IE
        addr_phase(1'b1, IE_OFS);
        @(negedge HCLK);
        HWDATA = 32'h0000_0055;
        addr_phase(1'b0, IE_OFS);
        @(negedge HCLK);
        idle();
        check("ie_raw", HRDATA, 32'h0000_0055);

        // Reset pulsed in the middle of a write data phase
        addr_phase(1'b1, DATA_OFS);
        @(negedge HCLK);
        idle();
        HWDATA = 32'h0000_BEEF;
        #2 HRESETn = 1'b0;
        #1 check("arst_gpioout", 32'(GPIOOUT[W-1:0]), 32'h0);
        check("arst_gpioen", 32'(GPIOEN), 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        bus_read(DATA_OFS, rd);
        check("arst_data", rd, 32'h0);
        bus_read(IE_OFS, rd);
        check("arst_ie", rd, 32'h0);
        bus_read(IS_OFS, rd);
        check("arst_is", rd, 32'h0);
        check("arst_irq", 32'(IRQ), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
